// File: rtl/mem_copy_master_pkg.sv
// Shared definitions for the word-granular memory copy master:
// FSM state encoding, write-strobe constants and the address stride.
package mem_copy_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP
    } state_t;

    localparam logic [3:0]  WSTRB_READ = 4'h0;
    localparam logic [3:0]  WSTRB_WORD = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mem_req_watchdog.sv
// Per-request wait counter for native-interface bus masters. The count
// restarts whenever 'clear' is high and advances on every 'enable' cycle.
// 'expired' is raised in the cycle that would bring the count to TIMEOUT,
// so a master holding a registered mem_valid can drop it exactly after
// TIMEOUT request cycles. TIMEOUT = 0 disables expiry.
module mem_req_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int LIMIT = (TIMEOUT == 0) ? 0 : int'(TIMEOUT) - 1;

    logic [CW-1:0] count;

    // Count request cycles that ended without an accepted mem_ready.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (TIMEOUT != 0)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count == CW'(LIMIT));

endmodule

// File: rtl/mem_copy_master.sv
// Block-copy bus master: for every word, one read from the source address
// followed by one write of that word to the destination address, with a
// mandatory idle cycle on mem_valid after every request. All bus outputs
// are registered and held constant while mem_valid is high.
module mem_copy_master
    import mem_copy_master_pkg::*;
#(
    parameter int          LEN_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LEN_WIDTH-1:0] words_done,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [31:0]          mem_rdata
);

    state_t               state;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [31:0]          buffer;
    logic                 first_q;
    logic                 in_request;
    logic                 accept;
    logic                 expired;
    logic [3:0]           unused_addr_bits;

    // Copies are word-granular, so the byte offset of both addresses is dropped.
    assign unused_addr_bits = {src_addr[1:0], dst_addr[1:0]};

    // A responder may still be holding mem_ready from the previous request
    // during the first cycle of a new one, so that cycle never completes.
    assign in_request = (state == RD) || (state == WR);
    assign accept     = in_request && mem_valid && mem_ready && !first_q;

    mem_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_request),
        .enable  (in_request && !accept),
        .expired (expired)
    );

    // Copy sequencer: steps through read, gap, write, gap for each word and
    // drives every bus and status output from registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            buffer     <= '0;
            first_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= WSTRB_READ;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        words_done <= '0;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            src_q     <= {src_addr[31:2], 2'b00};
                            dst_q     <= {dst_addr[31:2], 2'b00};
                            len_q     <= len;
                            busy      <= 1'b1;
                            state     <= RD;
                            first_q   <= 1'b1;
                            mem_valid <= 1'b1;
                            mem_addr  <= {src_addr[31:2], 2'b00};
                            mem_wdata <= '0;
                            mem_wstrb <= WSTRB_READ;
                        end
                    end
                end
                RD: begin
                    first_q <= 1'b0;
                    if (accept) begin
                        buffer    <= mem_rdata;
                        mem_valid <= 1'b0;
                        state     <= RD_GAP;
                    end else if (expired) begin
                        mem_valid <= 1'b0;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RD_GAP: begin
                    state     <= WR;
                    first_q   <= 1'b1;
                    mem_valid <= 1'b1;
                    mem_addr  <= dst_q;
                    mem_wdata <= buffer;
                    mem_wstrb <= WSTRB_WORD;
                end
                WR: begin
                    first_q <= 1'b0;
                    if (accept) begin
                        words_done <= words_done + 1'b1;
                        src_q      <= src_q + WORD_BYTES;
                        dst_q      <= dst_q + WORD_BYTES;
                        mem_valid  <= 1'b0;
                        state      <= WR_GAP;
                        if ((words_done + 1'b1) == len_q) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end else if (expired) begin
                        mem_valid <= 1'b0;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR_GAP: begin
                    if (words_done == len_q) begin
                        state <= IDLE;
                    end else begin
                        state     <= RD;
                        first_q   <= 1'b1;
                        mem_valid <= 1'b1;
                        mem_addr  <= src_q;
                        mem_wdata <= '0;
                        mem_wstrb <= WSTRB_READ;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
